// File: rtl/data_mem_responder.sv
// M-stage data-bus responder: word RAM, free-running cycle counter and console TX byte FIFO.
// Loads are combinational from Addr; stores, counter and FIFO state update on the rising edge.
// Never back-pressures the core. A full FIFO drops the byte and sets a sticky overflow flag.
module data_mem_responder #(
    parameter int Data_Width2 = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [Data_Width2-1:0] Addr,
    input  logic [Data_Width2-1:0] Write_Data,
    input  logic                   MemWriteM,
    output logic [Data_Width2-1:0] Read_Data,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] DEPTH_C = 8'(FIFO_DEPTH);
    localparam logic [Data_Width2-1:0] A_CYCLE  = Data_Width2'(32'h4000_0000);
    localparam logic [Data_Width2-1:0] A_TXDATA = Data_Width2'(32'h4000_0004);
    localparam logic [Data_Width2-1:0] A_STATUS = Data_Width2'(32'h4000_0008);

    logic [Data_Width2-1:0] r_mem  [MEM_DEPTH];
    logic [7:0]             r_fifo [FIFO_DEPTH];
    logic [Data_Width2-1:0] r_cycle;
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [7:0]             r_count;
    logic                   r_ovf;
    logic                   r_tx_valid;
    logic [7:0]             r_tx_data;

    logic                   w_sel_ram;
    logic                   w_sel_cycle;
    logic                   w_sel_tx;
    logic                   w_sel_status;
    logic [AW-1:0]          w_idx;
    logic                   w_we;
    logic                   w_ram_we;
    logic                   w_cycle_wr;
    logic                   w_ovf_clr;
    logic                   w_push_req;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_drop;
    logic                   w_full;
    logic [PW-1:0]          w_rd_ptr_inc;
    logic [7:0]             w_count_nxt;
    logic [7:0]             w_head_nxt;
    logic [Data_Width2-1:0] w_status;
    logic                   w_addr_unused;

    // Byte offset is ignored: every access is a whole word.
    assign w_addr_unused = ^Addr[1:0];

    assign w_sel_ram    = (Addr[Data_Width2-1 -: 4] == 4'h0);
    assign w_sel_cycle  = (Addr[Data_Width2-1:2] == A_CYCLE[Data_Width2-1:2]);
    assign w_sel_tx     = (Addr[Data_Width2-1:2] == A_TXDATA[Data_Width2-1:2]);
    assign w_sel_status = (Addr[Data_Width2-1:2] == A_STATUS[Data_Width2-1:2]);
    assign w_idx        = Addr[AW+1:2];

    assign w_we       = MemWriteM & ~RST;
    assign w_ram_we   = w_we & w_sel_ram;
    assign w_cycle_wr = w_we & w_sel_cycle;
    assign w_ovf_clr  = w_we & w_sel_status & Write_Data[16];

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_full       = (r_count == DEPTH_C);
    assign w_pop        = r_tx_valid & tx_ready;
    assign w_push_req   = w_we & w_sel_tx;
    assign w_push       = w_push_req & (~w_full | w_pop);
    assign w_drop       = w_push_req & ~w_push;
    assign w_rd_ptr_inc = r_rd_ptr + PW'(1);

    assign w_status = Data_Width2'({15'b0, r_ovf, 7'b0, w_full, r_count});

    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push & ~w_pop) begin
            w_count_nxt = r_count + 8'd1;
        end else if (~w_push & w_pop) begin
            w_count_nxt = r_count - 8'd1;
        end
    end

    // Next registered head: the pushed byte bypasses storage when it becomes the head.
    always_comb begin
        w_head_nxt = r_tx_data;
        if (w_count_nxt == 8'd0) begin
            w_head_nxt = 8'd0;
        end else if (w_pop) begin
            w_head_nxt = (r_count == 8'd1) ? Write_Data[7:0] : r_fifo[w_rd_ptr_inc];
        end else if (r_count == 8'd0) begin
            w_head_nxt = Write_Data[7:0];
        end
    end

    always_comb begin
        Read_Data = '0;
        if (w_sel_ram) begin
            Read_Data = r_mem[w_idx];
        end else if (w_sel_cycle) begin
            Read_Data = r_cycle;
        end else if (w_sel_status) begin
            Read_Data = w_status;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_ram_we) begin
            r_mem[w_idx] <= Write_Data;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= Write_Data[7:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cycle    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_cycle <= w_cycle_wr ? Write_Data : r_cycle + Data_Width2'(1);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            r_count    <= w_count_nxt;
            r_tx_valid <= (w_count_nxt != 8'd0);
            r_tx_data  <= w_head_nxt;
            // A drop on the same edge as a clear leaves the flag set.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized bench for data_mem_responder against a queue/array reference model.
module tb_data_mem_responder;
    localparam int MD = 256;
    localparam int FD = 4;
    localparam int AW = $clog2(MD);
    localparam logic [31:0] A_CYC = 32'h4000_0000;
    localparam logic [31:0] A_TX  = 32'h4000_0004;
    localparam logic [31:0] A_ST  = 32'h4000_0008;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] Addr = '0;
    logic [31:0] Write_Data = '0;
    logic        MemWriteM = 1'b0;
    logic [31:0] Read_Data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    always #5 CLK = ~CLK;

    data_mem_responder #(.Data_Width2(32), .MEM_DEPTH(MD), .FIFO_DEPTH(FD)) dut (
        .CLK(CLK), .RST(RST), .Addr(Addr), .Write_Data(Write_Data), .MemWriteM(MemWriteM),
        .Read_Data(Read_Data), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_mem [MD];
    logic [31:0] m_cyc;
    logic [7:0]  m_q [$];
    logic        m_ovf;
    logic        m_txz;
    bit          m_known = 0;

    logic [31:0] last_rd;
    logic        last_vld;
    logic [7:0]  last_txd;
    logic [7:0]  rx [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (a[31:28] == 4'h0) return m_mem[a[AW+1:2]];
        if (w == A_CYC) return m_cyc;
        if (w == A_ST) return {15'b0, m_ovf, 7'b0, (m_q.size() == FD), 8'(m_q.size())};
        return 32'd0;
    endfunction

    // Reference behaviour at one rising edge.
    task automatic model_edge(input logic [31:0] a, input logic [31:0] wd, input logic we,
                              input logic rdy, input logic rst);
        logic [31:0] w;
        bit drop;
        w = {a[31:2], 2'b00};
        drop = 0;
        if (rst) begin
            m_cyc = 0;
            m_q.delete();
            m_ovf = 0;
            m_txz = 1;
            m_known = 1;
            return;
        end
        if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
        if (we && w == A_TX) begin
            if (m_q.size() < FD) begin
                m_q.push_back(wd[7:0]);
                m_txz = 0;
            end else begin
                drop = 1;
            end
        end
        if (we && w == A_ST && wd[16]) m_ovf = 0;
        if (drop) m_ovf = 1;
        m_cyc = (we && w == A_CYC) ? wd : m_cyc + 32'd1;
        if (we && a[31:28] == 4'h0) m_mem[a[AW+1:2]] = wd;
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic we,
                        input logic rdy, input logic rst, input bit chk_rd);
        @(negedge CLK);
        Addr = a; Write_Data = wd; MemWriteM = we; tx_ready = rdy; RST = rst;
        #1;
        last_rd = Read_Data;
        last_vld = tx_valid;
        last_txd = tx_data;
        if (m_known) begin
            if (chk_rd) check("read_data", Read_Data, m_read(a));
            check("tx_valid", {31'b0, tx_valid}, {31'b0, m_q.size() != 0});
            if (m_q.size() != 0) check("tx_data", {24'b0, tx_data}, {24'b0, m_q[0]});
            else if (m_txz) check("tx_data_zero", {24'b0, tx_data}, 32'd0);
            if (tx_valid && rdy) rx.push_back(tx_data);
        end
        @(posedge CLK);
        model_edge(a, wd, we, rdy, rst);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic rdy);
        step(a, d, 1'b1, rdy, 1'b0, 1'b1);
    endtask

    task automatic rd(input logic [31:0] a, input logic rdy);
        step(a, 32'd0, 1'b0, rdy, 1'b0, 1'b1);
    endtask

    task automatic check_rx(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4,
                            input int n);
        logic [7:0] exp_b [5];
        exp_b = '{e0, e1, e2, e3, e4};
        check({tag, "_count"}, 32'(rx.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            check({tag, "_byte"}, {24'b0, (i < rx.size()) ? rx[i] : 8'h00}, {24'b0, exp_b[i]});
        end
    endtask

    initial begin
        logic [31:0] prior;
        logic [31:0] a;
        logic [31:0] d;
        int sel;

        step(32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < MD; i++) step(32'(i * 4), $urandom, 1'b1, 1'b0, 1'b0, 1'b0);

        // Counter from reset and across the wrap.
        step(32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) rd(A_CYC, 1'b0);
        check("cycle_at_5", last_rd, 32'd5);
        wr(A_CYC, 32'hFFFF_FFFE, 1'b0);
        rd(A_CYC, 1'b0); check("cycle_load", last_rd, 32'hFFFF_FFFE);
        rd(A_CYC, 1'b0); check("cycle_inc", last_rd, 32'hFFFF_FFFF);
        rd(A_CYC, 1'b0); check("cycle_wrap", last_rd, 32'h0000_0000);

        // RAM store, old word on the store cycle, alias.
        prior = m_mem[4];
        if (prior == 32'hDEAD_BEEF) begin
            wr(32'h10, 32'h0BAD_F00D, 1'b0);
            prior = 32'h0BAD_F00D;
        end
        wr(32'h10, 32'hDEAD_BEEF, 1'b0);
        check("ram_store_cycle_old", last_rd, prior);
        rd(32'h10, 1'b0);  check("ram_load", last_rd, 32'hDEAD_BEEF);
        rd(32'h413, 1'b0); check("ram_alias", last_rd, 32'hDEAD_BEEF);

        // Fill past capacity with the consumer stalled, then drain.
        for (int b = 8'h41; b <= 8'h45; b++) wr(A_TX, 32'(b), 1'b0);
        rd(A_ST, 1'b0); check("status_full_ovf", last_rd, 32'h0001_0104);
        rx.delete();
        for (int k = 0; k < 6; k++) rd(A_ST, 1'b1);
        check_rx("drain1", 8'h41, 8'h42, 8'h43, 8'h44, 8'h00, 4);
        check("drained_valid", {31'b0, last_vld}, 32'd0);
        wr(A_ST, 32'h0001_0000, 1'b0);
        rd(A_ST, 1'b0); check("status_ovf_clear", last_rd, 32'd0);

        // Push into a full FIFO while the head leaves.
        for (int b = 8'h61; b <= 8'h64; b++) wr(A_TX, 32'(b), 1'b0);
        rx.delete();
        wr(A_TX, 32'h55, 1'b1);
        rd(A_ST, 1'b0); check("status_push_pop_full", last_rd, 32'h0000_0104);
        for (int k = 0; k < 6; k++) rd(A_ST, 1'b1);
        check_rx("drain2", 8'h61, 8'h62, 8'h63, 8'h64, 8'h55, 5);

        // Reset with bytes queued; the store during reset must be ignored.
        for (int b = 8'h71; b <= 8'h73; b++) wr(A_TX, 32'(b), 1'b0);
        wr(A_CYC, 32'd100, 1'b0);
        rd(A_CYC, 1'b0); check("cycle_100", last_rd, 32'd100);
        step(32'h10, 32'hBAD0_BAD0, 1'b1, 1'b0, 1'b1, 1'b1);
        rd(A_CYC, 1'b0); check("rst_cycle0", last_rd, 32'd0);
        check("rst_tx_valid", {31'b0, last_vld}, 32'd0);
        check("rst_tx_data", {24'b0, last_txd}, 32'd0);
        rd(A_CYC, 1'b0); check("rst_cycle1", last_rd, 32'd1);
        rd(A_ST, 1'b0);  check("rst_status", last_rd, 32'd0);
        rd(32'h10, 1'b0); check("rst_ram_kept", last_rd, 32'hDEAD_BEEF);

        // Unmapped MMIO word.
        wr(32'h4000_000C, 32'h1234, 1'b0);
        rd(32'h4000_000C, 1'b0); check("unmapped_read", last_rd, 32'd0);
        rd(A_ST, 1'b0); check("unmapped_status", last_rd, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 9);
            d = $urandom;
            case (sel)
                0, 1, 2, 3: a = {4'h0, 28'($urandom)};
                4: begin
                    a = A_CYC | 32'($urandom_range(0, 3));
                    if ($urandom_range(0, 3) == 0) d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                end
                5, 6: a = A_TX;
                7: a = A_ST;
                default: a = ($urandom_range(0, 1) == 0) ? 32'h4000_000C + 32'($urandom_range(0, 8) * 4)
                                                         : {4'h5, 28'($urandom)};
            endcase
            step(a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 99) == 0), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
